param_rr_arbiter: RTL and testbench

PARAM_RR_ARBITER -- requirements
Module: param_rr_arbiter

---
 rtl/param_rr_arbiter.sv | 119 +++++++++++
 tb/tb_param_rr_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/param_rr_arbiter.sv
// Round-robin arbiter with bounded grant tenure, steering the owner's serial bit onto q.
// The grant hands over without an idle cycle when another requester is waiting.
module param_rr_arbiter #(
  parameter int N    = 4,
  parameter int HOLD = 3,
  parameter int CW   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] d,
  output logic [N-1:0] gnt,
  output logic         q,
  output logic         busy
);

  localparam int PW = $clog2(N);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr, ptr_nxt;
  logic [PW-1:0]   owner, owner_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [N-1:0]    gnt_nxt;
  logic            q_nxt, busy_nxt;
  logic [PW-1:0]   win;
  logic            win_vld;
  logic [PW:0]     sum;
  logic [PW-1:0]   idx;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
    if (int'(v) == N - 1) return '0;
    return v + 1'b1;
  endfunction

  // Scan from ptr upward (mod N); the first requester found wins.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      idx = sum[PW-1:0];
      if (!win_vld && req[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    gnt_nxt   = gnt;
    busy_nxt  = busy;
    q_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_nxt = GRANT;
          owner_nxt = win;
          cnt_nxt   = CW'(HOLD - 1);
          ptr_nxt   = wrap_inc(win);
          gnt_nxt   = {{(N-1){1'b0}}, 1'b1} << win;
          busy_nxt  = 1'b1;
        end else begin
          gnt_nxt  = '0;
          busy_nxt = 1'b0;
          cnt_nxt  = '0;
        end
      end
      GRANT: begin
        q_nxt = d[owner];
        if (req[owner] && cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else if (win_vld) begin
          // ptr already sits past the owner, so it is considered last.
          owner_nxt = win;
          cnt_nxt   = CW'(HOLD - 1);
          ptr_nxt   = wrap_inc(win);
          gnt_nxt   = {{(N-1){1'b0}}, 1'b1} << win;
          busy_nxt  = 1'b1;
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          gnt_nxt   = '0;
          busy_nxt  = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      cnt   <= '0;
      ptr   <= '0;
      gnt   <= '0;
      busy  <= 1'b0;
      q     <= 1'b0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      cnt   <= cnt_nxt;
      ptr   <= ptr_nxt;
      gnt   <= gnt_nxt;
      busy  <= busy_nxt;
      q     <= q_nxt;
    end
  end

endmodule

// File: tb/tb_param_rr_arbiter.sv
// Directed bench for param_rr_arbiter: N=4/HOLD=3 instance plus a HOLD=1 instance.
module tb_param_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, d, req1;
  logic [3:0] gnt, gnt1;
  logic       q, busy, q1, busy1;
  logic [3:0] ex;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  param_rr_arbiter #(.N(4), .HOLD(3), .CW(4)) u_dut (
    .clk(clk), .rst(rst), .req(req), .d(d), .gnt(gnt), .q(q), .busy(busy)
  );

  param_rr_arbiter #(.N(4), .HOLD(1), .CW(1)) u_dut_h1 (
    .clk(clk), .rst(rst), .req(req1), .d(d), .gnt(gnt1), .q(q1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Pulse reset between clock edges.
  task automatic rst_pulse;
    #2 rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    req  = '0;
    d    = '0;
    req1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", 8'(gnt), 8'h0);
    check("rst_busy", 8'(busy), 8'h0);
    check("rst_q", 8'(q), 8'h0);
    check("rst_gnt_h1", 8'(gnt1), 8'h0);
    rst = 1'b0;

    // Single persistent requester is regranted with no gap.
    req = 4'b0010;
    for (int e = 1; e <= 7; e++) begin
      step();
      check("solo_gnt", 8'(gnt), 8'h02);
      check("solo_busy", 8'(busy), 8'h1);
    end
    req = 4'b0000;
    step();
    check("solo_idle_gnt", 8'(gnt), 8'h0);
    check("solo_idle_busy", 8'(busy), 8'h0);

    // All request: rotate 0,1,2,3,0 with 3-cycle tenures from ptr=0.
    rst_pulse();
    req = 4'b1111;
    for (int e = 1; e <= 13; e++) begin
      step();
      ex = 4'b0001 << (((e - 1) / 3) % 4);
      check("rr_gnt", 8'(gnt), 8'(ex));
    end

    // Owner drops early; waiting requester takes over on the next edge.
    req = 4'b0000;
    rst_pulse();
    req = 4'b0001;
    step();
    check("drop_gnt0", 8'(gnt), 8'h01);
    step();
    check("drop_gnt1", 8'(gnt), 8'h01);
    req = 4'b0100;
    step();
    check("drop_handover", 8'(gnt), 8'h04);
    check("drop_busy", 8'(busy), 8'h1);

    // Data steering: q follows d[owner] one cycle later, 0 in IDLE.
    req = 4'b0000;
    rst_pulse();
    d   = 4'b0000;
    req = 4'b0010;
    step();
    check("data_gnt", 8'(gnt), 8'h02);
    check("data_q_first", 8'(q), 8'h0);
    d = 4'b0010;
    step();
    check("data_q1", 8'(q), 8'h1);
    d = 4'b1101;
    step();
    check("data_q0", 8'(q), 8'h0);
    d = 4'b0010;
    step();
    check("data_q1b", 8'(q), 8'h1);
    req = 4'b0000;
    step();
    check("data_end_gnt", 8'(gnt), 8'h0);
    check("data_end_q", 8'(q), 8'h1);
    step();
    check("data_idle_q", 8'(q), 8'h0);
    check("data_idle_busy", 8'(busy), 8'h0);

    // Asynchronous reset mid-tenure.
    req = 4'b0001;
    d   = 4'b0001;
    step();
    check("arst_gnt", 8'(gnt), 8'h01);
    step();
    check("arst_q_pre", 8'(q), 8'h1);
    #2 rst = 1'b1;
    #1;
    check("arst_gnt_now", 8'(gnt), 8'h0);
    check("arst_q_now", 8'(q), 8'h0);
    check("arst_busy_now", 8'(busy), 8'h0);
    rst = 1'b0;
    req = 4'b1000;
    d   = 4'b0000;
    step();
    check("arst_regrant", 8'(gnt), 8'h08);
    check("arst_busy", 8'(busy), 8'h1);

    // HOLD=1: one-cycle tenures alternate between two requesters.
    req  = 4'b0000;
    req1 = 4'b0011;
    rst_pulse();
    for (int e = 1; e <= 6; e++) begin
      step();
      ex = (e % 2 == 1) ? 4'b0001 : 4'b0010;
      check("h1_gnt", 8'(gnt1), 8'(ex));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
